// File: rtl/filter_sync_tx_pacer.sv
// ---------------------------------------------------------------------------
// filter_sync_tx_pacer
//
// Domain-A source stage for filter_sync.bus_in. Bus update requests are
// buffered in a small FIFO and driven onto a registered bus. Each value is
// held for at least HOLD_CYCLES clk_a cycles, so the downstream filter
// synchronizer always sees a settled value and never misses an update.
//
// Optional feature macro: FSP_OVERWRITE_EN
//   undefined : wr_ready = !full, pushes into a full FIFO are back-pressured,
//               overwrite is tied 0.
//   defined   : wr_ready is tied 1. A push into a full FIFO with no pop on the
//               same edge replaces the newest entry (latest value wins) and
//               pulses overwrite for one cycle. With a pop on the same edge
//               the push is stored normally.
//
// Parameters
//   WIDTH        bus width (matches filter_sync)
//   HOLD_CYCLES  minimum clk_a cycles each value stays on bus_out, >= 2
//   DEPTH        request FIFO entries, power of 2, >= 2
//   RESET_VALUE  bus_out value while in reset
//
// Ports
//   clk_a      in   domain-A clock
//   rstb_a     in   async active-low reset (release synchronised upstream)
//   wr_data    in   requested bus value
//   wr_valid   in   request strobe
//   wr_ready   out  request accepted on a clk_a edge with wr_valid & wr_ready
//   bus_out    out  registered bus, connect to filter_sync.bus_in
//   busy       out  1 while a value is being held (state HOLD)
//   pending    out  FIFO occupancy
//   overwrite  out  1-cycle pulse when a full-FIFO entry was replaced
//   state_dbg  out  FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a request transfers on every rising clk_a edge where wr_valid
// and wr_ready are both 1. wr_ready is a register derived from occupancy,
// never from wr_valid, so a full FIFO refuses a push even when a pop happens
// on the same edge. The requester must hold wr_data stable while wr_valid is
// high and not yet accepted.
// ---------------------------------------------------------------------------
module filter_sync_tx_pacer #(
   parameter int unsigned      WIDTH       = 4,
   parameter int unsigned      HOLD_CYCLES = 8,
   parameter int unsigned      DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                   clk_a,
   input  logic                   rstb_a,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   output logic [WIDTH-1:0]       bus_out,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   overwrite,
   output logic                   state_dbg
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   // Reload value: the load edge itself is the first hold cycle.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   generate
      if (HOLD_CYCLES < 2) begin : g_bad_hold
         $error("filter_sync_tx_pacer: HOLD_CYCLES must be >= 2");
      end
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("filter_sync_tx_pacer: DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_bus;
   logic             r_busy;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_mem_we;
   logic [PTR_W-1:0] w_mem_addr;
   logic [OCC_W-1:0] w_occ_nxt;

   assign w_empty = (r_occ == '0);
   assign w_full  = (r_occ == OCC_FULL);

   // The head is taken when idle, or on the last hold cycle so that a
   // back-to-back value follows without a bubble cycle.
   assign w_pop = !w_empty && ((r_state == ST_IDLE) || (r_cnt == '0));

   // ------------------------------------------------------------------
   // Push path (feature-dependent)
   // ------------------------------------------------------------------
`ifdef FSP_OVERWRITE_EN
   logic w_replace;
   logic r_overwrite;

   // Full with nothing leaving: rewrite the newest slot in place instead
   // of advancing the write pointer.
   assign w_replace  = wr_valid && w_full && !w_pop;
   assign w_push     = wr_valid && !w_replace;
   assign w_mem_we   = wr_valid;
   assign w_mem_addr = w_replace ? (r_wr_ptr - PTR_W'(1)) : r_wr_ptr;

   always_ff @(posedge clk_a or negedge rstb_a) begin
      if (!rstb_a) begin
         r_overwrite <= 1'b0;
      end else begin
         r_overwrite <= w_replace;
      end
   end

   assign wr_ready  = 1'b1;
   assign overwrite = r_overwrite;
`else
   logic r_wr_ready;

   assign w_push     = wr_valid && r_wr_ready;
   assign w_mem_we   = w_push;
   assign w_mem_addr = r_wr_ptr;

   // Registered from next occupancy: no pop look-ahead into the ready path.
   always_ff @(posedge clk_a or negedge rstb_a) begin
      if (!rstb_a) begin
         r_wr_ready <= 1'b1;
      end else begin
         r_wr_ready <= (w_occ_nxt != OCC_FULL);
      end
   end

   assign wr_ready  = r_wr_ready;
   assign overwrite = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FIFO occupancy and pointers
   // ------------------------------------------------------------------
   always_comb begin
      w_occ_nxt = r_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
         2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
         default: w_occ_nxt = r_occ;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk_a or negedge rstb_a) begin
      if (!rstb_a) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_occ <= w_occ_nxt;
      end
   end

   // Entry storage needs no reset: a reset empties the FIFO through the
   // pointers, so stale contents are never read.
   always_ff @(posedge clk_a) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Pacing FSM: IDLE waits for data, HOLD keeps bus_out stable for
   // HOLD_CYCLES edges (load edge counts as the first).
   // ------------------------------------------------------------------
   always_ff @(posedge clk_a or negedge rstb_a) begin
      if (!rstb_a) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bus   <= RESET_VALUE;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_bus   <= r_mem[r_rd_ptr];
                  r_cnt   <= HOLD_LAST;
                  r_state <= ST_HOLD;
                  r_busy  <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (w_pop) begin
                  r_bus <= r_mem[r_rd_ptr];
                  r_cnt <= HOLD_LAST;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus_out   = r_bus;
   assign busy      = r_busy;
   assign pending   = r_occ;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_filter_sync_tx_pacer.sv
// ---------------------------------------------------------------------------
// tb_filter_sync_tx_pacer
//
// Directed bench for filter_sync_tx_pacer (WIDTH=4, HOLD_CYCLES=8, DEPTH=4,
// RESET_VALUE=0). Inputs are driven and outputs sampled on the falling edge
// of clk_a, so every sample reflects the rising edge just passed. Builds with
// or without FSP_OVERWRITE_EN; expectations follow the selected behaviour.
// ---------------------------------------------------------------------------
module tb_filter_sync_tx_pacer;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

`ifdef FSP_OVERWRITE_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic             clk_a    = 1'b0;
   logic             rstb_a   = 1'b0;
   logic [WIDTH-1:0] wr_data  = '0;
   logic             wr_valid = 1'b0;

   logic             wr_ready;
   logic [WIDTH-1:0] bus_out;
   logic             busy;
   logic [$clog2(DEPTH):0] pending;
   logic             overwrite;
   logic             state_dbg;

   always #5 clk_a = ~clk_a;

   filter_sync_tx_pacer #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (8),
      .DEPTH       (DEPTH),
      .RESET_VALUE (4'h0)
   ) u_dut (
      .clk_a     (clk_a),
      .rstb_a    (rstb_a),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .bus_out   (bus_out),
      .busy      (busy),
      .pending   (pending),
      .overwrite (overwrite),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_pass  = 0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk_a);
   endtask

   // One push into an empty, idle pacer; walks the whole hold window.
   task automatic single_hold(input string t, input logic [3:0] prev_v, input logic [3:0] v);
      wr_data  = v;
      wr_valid = 1'b1;
      step();                                   // edge t: push
      wr_valid = 1'b0;
      check({t, "_pend_t"}, pending, 1);
      check({t, "_bus_t"}, bus_out, prev_v);    // no write-to-bus bypass
      step();                                   // edge t+1: pop
      check({t, "_bus_t1"}, bus_out, v);
      check({t, "_busy_t1"}, busy, 1);
      check({t, "_pend_t1"}, pending, 0);
      check({t, "_state_t1"}, state_dbg, 1);
      for (int k = 2; k <= 8; k++) begin
         step();
         check({t, "_hold"}, {busy, bus_out}, {1'b1, v});
      end
      step();                                   // edge t+9: back to IDLE
      check({t, "_busy_t9"}, busy, 0);
      check({t, "_bus_t9"}, bus_out, v);
      check({t, "_state_t9"}, state_dbg, 0);
   endtask

   // Expected bus_out after edge t+k of the burst: values 1..4 then last_v,
   // each taking over 8 edges after the previous one, starting at t+1.
   function automatic logic [3:0] burst_bus(input int k, input logic [3:0] last_v);
      int idx;
      if (k < 1) return 4'hA;
      idx = (k - 1) / 8;
      if (idx >= 4) return last_v;
      return 4'(idx + 1);
   endfunction

   function automatic int burst_pend(input int k);
      int n;
      if (k == 0) return 1;
      if (k <= 4) return k;
      n = 4;
      if (k >= 9)  n--;
      if (k >= 17) n--;
      if (k >= 25) n--;
      if (k >= 33) n--;
      return n;
   endfunction

   // Pushes 1,2,3,4,5,F on edges t..t+5. The sixth push finds the FIFO
   // full with no pop: refused normally, replaces 5 in overwrite mode.
   task automatic burst_test();
      logic [3:0] last_v;
      logic [3:0] prev_bus;
      logic       exp_ready;
      last_v   = OVR ? 4'hF : 4'h5;
      exp_q    = {4'h1, 4'h2, 4'h3, 4'h4, last_v};
      prev_bus = 4'hA;
      for (int k = 0; k <= 45; k++) begin
         if (k <= 5) begin
            wr_valid = 1'b1;
            wr_data  = (k == 5) ? 4'hF : 4'(k + 1);
         end else begin
            wr_valid = 1'b0;
         end
         step();                                // now after edge t+k
         exp_ready = OVR ? 1'b1 : !((k >= 4) && (k <= 8));
         check("burst_bus", bus_out, burst_bus(k, last_v));
         check("burst_pend", pending, burst_pend(k));
         check("burst_ready", wr_ready, exp_ready);
         check("burst_busy", busy, (k >= 1) && (k <= 40));
         check("burst_ovr", overwrite, OVR && (k == 5));
         if (bus_out !== prev_bus) begin
            if (exp_q.size() == 0) begin
               check("burst_extra_change", bus_out, prev_bus);
            end else begin
               check("burst_seq", bus_out, exp_q.pop_front());
            end
            prev_bus = bus_out;
         end
      end
      check("burst_seq_left", exp_q.size(), 0);
   endtask

   task automatic reset_mid_hold();
      wr_valid = 1'b1;
      wr_data  = 4'h1;
      step();                                   // t: push 1
      wr_data  = 4'h2;
      step();                                   // t+1: pop 1, push 2
      wr_data  = 4'h3;
      step();                                   // t+2: push 3
      wr_valid = 1'b0;
      check("mid_pend", pending, 2);
      check("mid_bus", bus_out, 1);
      check("mid_busy", busy, 1);
      step();                                   // t+3: still holding
      check("mid_pend_t3", pending, 2);
      rstb_a = 1'b0;
      #1;
      check("arst_bus", bus_out, 0);
      check("arst_pend", pending, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", wr_ready, 1);
      check("arst_state", state_dbg, 0);
      step();
      rstb_a = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         check("post_arst_quiet", {busy, pending, bus_out}, 0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      // Reset held with wr_valid asserted: nothing may be queued.
      rstb_a   = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 4'h5;
      repeat (3) step();
      check("rst_bus", bus_out, 0);
      check("rst_pend", pending, 0);
      check("rst_ready", wr_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_ovr", overwrite, 0);
      check("rst_state", state_dbg, 0);
      rstb_a   = 1'b1;
      wr_valid = 1'b0;
      repeat (2) step();
      check("rel_bus", bus_out, 0);
      check("rel_pend", pending, 0);
      check("rel_busy", busy, 0);

      single_hold("single", 4'h0, 4'hA);
      repeat (3) begin
         step();
         check("gap_idle", {busy, bus_out}, {1'b0, 4'hA});
      end

      // Same value as the bus: still queued, still a full hold.
      single_hold("same", 4'hA, 4'hA);

      burst_test();
      reset_mid_hold();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
